// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame scheduler: FSM states, pixel word,
// colour reordering and the latch-gap length derived from the clock frequency.
package ws2812_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DRAIN, LATCH} state_t;

    typedef logic [23:0] pixel_t;

    // 80 us latch gap: clk_fre / 12_500 cycles.
    function automatic int latch_cycles(input int clk_fre);
        return clk_fre / 12_500;
    endfunction

    localparam int RESET_CYCLES_27M = latch_cycles(27_000_000);

    // Host stores {R,G,B}; the LED chain expects {G,R,B}.
    function automatic pixel_t rgb_to_grb(input pixel_t rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_frame_sched_if.sv
// Host write bus and pixel stream between host/encoder (master) and the scheduler (slave).
interface ws2812_frame_sched_if #(
    parameter int ADDR_W = 3
);
    import ws2812_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_data;
    logic              commit;
    logic              px_valid;
    pixel_t            px_data;
    logic              px_ready;
    logic              enc_busy;

    modport master (
        output wr_en, wr_addr, wr_data, commit, px_ready, enc_busy,
        input  px_valid, px_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, px_ready, enc_busy,
        output px_valid, px_data
    );

endinterface

// File: rtl/ws2812_pixel_ram.sv
// Double-banked pixel store: one write port, one registered read port, address {bank, index}.
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: on each frame tick streams one scaled GRB word per LED from the
// display bank to the bit encoder, waits for the encoder to drain, then holds the latch gap.
module ws2812_frame_sched
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int ADDR_W       = 3,
    parameter int CLK_FRE      = 27_000_000,
    parameter int FRAME_CYCLES = 450_000,
    parameter int RESET_CYCLES = latch_cycles(CLK_FRE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [7:0]           brightness,
    ws2812_frame_sched_if.slave  bus,
    output logic                 swap_pending,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(FRAME_CYCLES);
    localparam int LAT_W  = $clog2(RESET_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_LEDS - 1);

    state_t            state, state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] idx;
    logic              disp_bank;
    logic [7:0]        bright_q;
    pixel_t            ram_rd_data, grb, scaled;
    logic              tick, frame_start, xfer, last_px, lat_end;
    logic              load_px, advance, done_now;

    assign tick        = (tick_cnt == TICK_LAST);
    assign frame_start = (state == IDLE) && tick && enable;
    assign xfer        = bus.px_valid && bus.px_ready;
    assign last_px     = (idx == IDX_LAST);
    assign lat_end     = (lat_cnt == LAT_LAST);

    // Host writes always target the bank not being displayed, so a frame in flight never changes.
    ws2812_pixel_ram #(.AW(ADDR_W + 1)) u_ram (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr ({~disp_bank, bus.wr_addr}),
        .wr_data (bus.wr_data),
        .rd_addr ({disp_bank, idx}),
        .rd_data (ram_rd_data)
    );

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    assign grb    = rgb_to_grb(ram_rd_data);
    assign scaled = {scale_ch(grb[23:16], bright_q),
                     scale_ch(grb[15:8],  bright_q),
                     scale_ch(grb[7:0],   bright_q)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (xfer) state_next = last_px ? DRAIN : FETCH;
            DRAIN:   if (!bus.enc_busy) state_next = LATCH;
            LATCH:   if (lat_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_px  = 1'b0;
        advance  = 1'b0;
        done_now = 1'b0;
        case (state)
            LOAD:    load_px  = 1'b1;
            SEND:    advance  = xfer;
            LATCH:   done_now = lat_end;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // A commit seen in the frame-start cycle survives the clear and is applied next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_bank    <= 1'b0;
            swap_pending <= 1'b0;
            bright_q     <= '0;
            idx          <= '0;
            lat_cnt      <= '0;
            bus.px_valid <= 1'b0;
            bus.px_data  <= '0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_done <= done_now;
            overrun    <= tick && (state != IDLE);
            lat_cnt    <= (state == LATCH) ? lat_cnt + 1'b1 : '0;
            if (bus.commit) begin
                swap_pending <= 1'b1;
            end else if (frame_start) begin
                swap_pending <= 1'b0;
            end
            if (frame_start) begin
                bright_q <= brightness;
                idx      <= '0;
                if (swap_pending) begin
                    disp_bank <= ~disp_bank;
                end
            end
            if (load_px) begin
                bus.px_data  <= scaled;
                bus.px_valid <= 1'b1;
            end
            if (advance) begin
                bus.px_valid <= 1'b0;
                idx          <= idx + 1'b1;
            end
        end
    end

endmodule
